dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-requester arbiter and sequencer in front of the single-ported, byte-addressed data memory.
//  Port 0 is instruction fetch; port 1 is the load/store unit. Winners are picked round-robin.
//  Drives the memory's load/store strobes for exactly one cycle per accepted request.
//  Captures the registered read data and returns it to the winner with a fixed 2-cycle latency.
//  Alignment and range errors are detected here; the memory is never strobed for a faulting request.
// PARAMETERS
//  MEM_BYTES  256  memory size in bytes; a request whose last byte is >= MEM_BYTES faults
// PORTS
//  clk            in   1        clock; all logic is rising-edge
//  rst            in   1        synchronous reset, active-high
//  req_valid      in   [1:0]    request pending, per port
//  req_ready      out  [1:0]    request accepted this cycle; handshake = valid & ready
//  req_addr       in   [1:0][31:0]  byte address
//  req_wdata      in   [1:0][31:0]  store data, LSB-aligned
//  req_we         in   [1:0]    1 = store, 0 = load
//  req_dw         in   [1:0][1:0]   width: 0 = byte, 1 = half, 2 = word, 3 = reserved
//  req_sign       in   [1:0]    sign-extend load data
//  resp_valid     out  [1:0]    1-cycle response pulse to the owning port
//  resp_rdata     out  32       load data; 0 for stores and errors
//  resp_err       out  1        response is a fault; qualified by resp_valid
//  mem_l          out  1        load strobe
//  mem_s          out  1        store strobe
//  mem_addr       out  32       address to memory
//  mem_wdata      out  32       store data to memory
//  mem_dw         out  2        width to memory
//  mem_sign       out  1        sign control to memory
//  mem_rdata      in   32       memory read data; registered, valid the cycle after mem_l
// BEHAVIOUR
//  Reset values: every output is 0 during and after reset; state = IDLE; last_grant = 1.
//  FSM states: IDLE -> ISSUE -> RESP -> IDLE. Every accepted request takes exactly 3 cycles.
//  Throughput: at most one request per 3 cycles.
//  IDLE:
//   - grant = the only valid port; if both are valid, grant = ~last_grant.
//   - req_ready[grant] = 1 combinationally, only in IDLE and only for the granted port.
//   - On handshake: latch addr, wdata, we, dw, sign and the port id; set last_grant = port id; go to ISSUE.
//   - Compute err at latch time:
//     - dw == 3;
//     - dw == 1 with addr[0] set;
//     - dw == 2 with addr[1:0] != 0;
//     - addr + size - 1 >= MEM_BYTES, computed 33 bits wide so there is no 32-bit wrap.
//  ISSUE:
//   - mem_addr, mem_wdata, mem_dw, mem_sign driven from the latches.
//   - mem_l = !we & !err; mem_s = we & !err.
//   - Next state RESP.
//  RESP:
//   - resp_valid[port] = 1.
//   - resp_err = err.
//   - resp_rdata = mem_rdata for a non-faulting load, else 0.
//   - Next state IDLE.
//  Latency: handshake at cycle T -> strobe at T+1 -> resp_valid at T+2 -> ready again at T+3.
//  Strobes: mem_l and mem_s are never high together, never high outside ISSUE, and are 0 whenever err = 1.
//  mem_* data outputs hold their last value outside ISSUE; only the strobes qualify them.
//  req_valid dropped without a handshake: no effect; round-robin pointer unchanged.
//  rst asserted in any state: next state IDLE, all outputs 0, in-flight response discarded (no resp_valid).
//   - A store strobed in ISSUE before rst is not undone.
//  Ignored inputs: requests arriving in ISSUE/RESP see ready = 0; mem_rdata is ignored outside RESP.
// TESTING
//  1 Reset: hold rst 3 cycles with both req_valid = 1 -> ready, strobes and resp_valid all stay 0.
//  2 Port 1 word load at 0x10, memory holds 0xDEADBEEF -> mem_l at T+1, resp_valid[1] at T+2 with 0xDEADBEEF, err = 0.
//  3 Both ports valid continuously -> grants go 0,1,0,1; each grant 3 cycles apart; resp_valid goes to the matching port.
//  4 Port 1 stores byte 0xA5 to 0x20, then loads signed byte from 0x20 -> mem_s once, then rdata = 0xFFFFFFA5.
//  5 Faulting requests:
//    - half load at 0x11 -> resp_err = 1, rdata = 0, mem_l never high;
//    - word store at 0xFE -> resp_err = 1, mem_s never high;
//    - dw = 3 -> resp_err = 1.
//  6 Assert rst during the ISSUE of a load -> no resp_valid; the next request after rst is served normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter/sequencer for the single-ported data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int MEM_BYTES = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0][31:0] req_addr,
    input  logic [1:0][31:0] req_wdata,
    input  logic [1:0]       req_we,
    input  logic [1:0][1:0]  req_dw,
    input  logic [1:0]       req_sign,
    output logic [1:0]       resp_valid,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic             mem_l,
    output logic             mem_s,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [1:0]       mem_dw,
    output logic             mem_sign,
    input  logic [31:0]      mem_rdata
);

    localparam logic [32:0] c_mem_bytes = 33'(MEM_BYTES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_last_grant;
    logic        r_port;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [1:0]  r_dw;
    logic        r_sign;
    logic        r_err;

    logic        w_grant;
    logic        w_hs;
    logic [31:0] w_sel_addr;
    logic [1:0]  w_sel_dw;
    logic [32:0] w_size;
    logic [32:0] w_last_byte;
    logic        w_err;

    // Contention goes to the port that did not win last time.
    assign w_grant    = (&req_valid) ? ~r_last_grant : req_valid[1];
    assign w_sel_addr = req_addr[w_grant];
    assign w_sel_dw   = req_dw[w_grant];

    always_comb begin
        case (w_sel_dw)
            2'd0:    w_size = 33'd1;
            2'd1:    w_size = 33'd2;
            default: w_size = 33'd4;
        endcase
    end

    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    assign w_last_byte = {1'b0, w_sel_addr} + w_size - 33'd1;
    assign w_err = (w_sel_dw == 2'd3)
                 | ((w_sel_dw == 2'd1) & w_sel_addr[0])
                 | ((w_sel_dw == 2'd2) & (w_sel_addr[1:0] != 2'b00))
                 | (w_last_byte >= c_mem_bytes);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_hs       = 1'b0;
        req_ready  = 2'b00;
        mem_l      = 1'b0;
        mem_s      = 1'b0;
        resp_valid = 2'b00;
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req_valid) begin
                    req_ready[w_grant] = 1'b1;
                    w_hs               = 1'b1;
                    w_next             = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_l  = ~r_we & ~r_err;
                mem_s  = r_we & ~r_err;
                w_next = S_RESP;
            end
            S_RESP: begin
                resp_valid[r_port] = 1'b1;
                resp_err           = r_err;
                if (!r_we && !r_err) begin
                    resp_rdata = mem_rdata;
                end
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Reset silences every output immediately, including an in-flight strobe.
        if (rst) begin
            w_hs       = 1'b0;
            req_ready  = 2'b00;
            mem_l      = 1'b0;
            mem_s      = 1'b0;
            resp_valid = 2'b00;
            resp_rdata = 32'd0;
            resp_err   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_we         <= 1'b0;
            r_dw         <= 2'd0;
            r_sign       <= 1'b0;
            r_err        <= 1'b0;
        end else if (w_hs) begin
            r_last_grant <= w_grant;
            r_port       <= w_grant;
            r_addr       <= w_sel_addr;
            r_wdata      <= req_wdata[w_grant];
            r_we         <= req_we[w_grant];
            r_dw         <= w_sel_dw;
            r_sign       <= req_sign[w_grant];
            r_err        <= w_err;
        end
    end

    // Data lines simply reflect the latches, so they hold outside ISSUE.
    assign mem_addr  = rst ? 32'd0 : r_addr;
    assign mem_wdata = rst ? 32'd0 : r_wdata;
    assign mem_dw    = rst ? 2'd0  : r_dw;
    assign mem_sign  = rst ? 1'b0  : r_sign;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Scoreboard bench for dmem_arbiter with a byte-array memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_addr = '0;
    logic [1:0][31:0] req_wdata = '0;
    logic [1:0]       req_we = '0;
    logic [1:0][1:0]  req_dw = '0;
    logic [1:0]       req_sign = '0;
    logic [1:0]       resp_valid;
    logic [31:0]      resp_rdata;
    logic             resp_err;
    logic             mem_l;
    logic             mem_s;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [1:0]       mem_dw;
    logic             mem_sign;
    logic [31:0]      mem_rdata = 32'd0;

    dmem_arbiter #(.MEM_BYTES(256)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
        .req_dw(req_dw), .req_sign(req_sign),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_l(mem_l), .mem_s(mem_s), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_dw(mem_dw), .mem_sign(mem_sign), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // strobe: 0 = none, 1 = load, 2 = store
    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          strobe;
        logic [31:0] addr;
        int          hs;
    } exp_t;
    exp_t sb[$];

    // Byte-addressed little-endian memory with registered read data.
    logic [7:0] mem_arr [0:255];

    function automatic logic [31:0] mem_read(input logic [7:0] a, input logic [1:0] dw, input logic sg);
        logic [7:0]  b;
        logic [15:0] h;
        b = mem_arr[a];
        h = {mem_arr[a + 8'd1], mem_arr[a]};
        case (dw)
            2'd0:    return sg ? {{24{b[7]}}, b} : {24'd0, b};
            2'd1:    return sg ? {{16{h[15]}}, h} : {16'd0, h};
            default: return {mem_arr[a + 8'd3], mem_arr[a + 8'd2], h};
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_s) begin
            for (int i = 0; i < (mem_dw == 2'd0 ? 1 : mem_dw == 2'd1 ? 2 : 4); i++)
                mem_arr[mem_addr[7:0] + 8'(i)] <= mem_wdata[8*i +: 8];
        end
        if (mem_l) mem_rdata <= mem_read(mem_addr[7:0], mem_dw, mem_sign);
    end

    // Monitor: strobe checked one cycle after handshake, response two cycles after.
    always @(negedge clk) begin
        exp_t e;
        if (mem_l && mem_s) check("strobe_overlap", 32'd1, 32'd0);
        if (sb.size() > 0 && cyc == sb[0].hs + 1) begin
            check("strobe", {30'd0, mem_s, mem_l},
                  sb[0].strobe == 1 ? 32'd1 : sb[0].strobe == 2 ? 32'd2 : 32'd0);
            if (sb[0].strobe != 0) check("mem_addr", mem_addr, sb[0].addr);
        end else if (mem_l || mem_s) begin
            check("stray_strobe", {30'd0, mem_s, mem_l}, 32'd0);
        end
        if (resp_valid != 2'b00) begin
            if (sb.size() == 0) begin
                check("stray_resp", {30'd0, resp_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_port", {30'd0, resp_valid}, (e.port == 1) ? 32'd2 : 32'd1);
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                check("resp_latency", 32'(cyc - e.hs), 32'd2);
            end
        end else if (sb.size() > 0 && cyc > sb[0].hs + 2) begin
            e = sb.pop_front();
            check("resp_missing", 32'd0, 32'd1);
        end
    end

    task automatic push_exp(input int port, input logic [31:0] rdata, input logic err,
                            input int strobe, input logic [31:0] addr);
        exp_t e;
        e.port = port; e.rdata = rdata; e.err = err;
        e.strobe = strobe; e.addr = addr; e.hs = cyc;
        sb.push_back(e);
    endtask

    task automatic issue(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we, input logic [1:0] dw, input logic sg,
                         input logic [31:0] exp_rdata, input logic exp_err);
        bit got = 0;
        @(posedge clk); #1;
        req_addr[port] = addr; req_wdata[port] = wdata; req_we[port] = we;
        req_dw[port] = dw; req_sign[port] = sg; req_valid[port] = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[port]) begin
                got = 1;
                push_exp(port, exp_rdata, exp_err, exp_err ? 0 : (we ? 2 : 1), addr);
                break;
            end
        end
        if (!got) check("handshake_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid[port] = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && sb.size() > 0; n++) @(posedge clk);
        if (sb.size() > 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic req(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic we, input logic [1:0] dw, input logic sg,
                       input logic [31:0] exp_rdata, input logic exp_err);
        issue(port, addr, wdata, we, dw, sg, exp_rdata, exp_err);
        drain();
    endtask

    initial begin
        int k;
        int last;
        int p;
        for (int i = 0; i < 256; i++) mem_arr[i] = 8'(i);
        {mem_arr[8'h13], mem_arr[8'h12], mem_arr[8'h11], mem_arr[8'h10]} = 32'hDEADBEEF;
        {mem_arr[8'h15], mem_arr[8'h14]} = 16'h1234;
        {mem_arr[8'hFF], mem_arr[8'hFE], mem_arr[8'hFD], mem_arr[8'hFC]} = 32'h12345678;

        // Reset held with both requesters pending
        rst = 1'b1; req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready", {30'd0, req_ready}, 32'd0);
            check("rst_strobes", {30'd0, mem_s, mem_l}, 32'd0);
            check("rst_resp", {30'd0, resp_valid}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 2'b00;
        @(negedge clk);
        check("idle_mem_addr", mem_addr, 32'd0);
        check("idle_resp_rdata", resp_rdata, 32'd0);

        // Single word load on port 1
        req(1, 32'h10, 32'd0, 1'b0, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0);

        // Round-robin with both ports always requesting
        @(posedge clk); #1;
        req_addr[0] = 32'h10; req_we[0] = 1'b0; req_dw[0] = 2'd2; req_sign[0] = 1'b0;
        req_addr[1] = 32'h14; req_we[1] = 1'b0; req_dw[1] = 2'd1; req_sign[1] = 1'b0;
        req_valid = 2'b11;
        k = 0; last = 0;
        for (int n = 0; n < 40 && k < 4; n++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) begin
                p = req_ready[1] ? 1 : 0;
                check("rr_grant", 32'(p), 32'(k % 2));
                if (k > 0) check("rr_gap", 32'(cyc - last), 32'd3);
                push_exp(p, p == 1 ? 32'h00001234 : 32'hDEADBEEF, 1'b0, 1, req_addr[p]);
                last = cyc;
                k++;
            end
        end
        check("rr_count", 32'(k), 32'd4);
        @(posedge clk); #1;
        req_valid = 2'b00;
        drain();

        // Store byte then signed byte load back
        req(1, 32'h20, 32'h000000A5, 1'b1, 2'd0, 1'b0, 32'd0, 1'b0);
        req(1, 32'h20, 32'd0, 1'b0, 2'd0, 1'b1, 32'hFFFFFFA5, 1'b0);

        // Faults and range boundaries
        req(0, 32'h11, 32'd0, 1'b0, 2'd1, 1'b0, 32'd0, 1'b1);
        req(1, 32'hFE, 32'h11223344, 1'b1, 2'd2, 1'b0, 32'd0, 1'b1);
        req(0, 32'h00, 32'd0, 1'b0, 2'd3, 1'b0, 32'd0, 1'b1);
        req(0, 32'hFC, 32'd0, 1'b0, 2'd2, 1'b0, 32'h12345678, 1'b0);
        req(1, 32'hFFFFFFFC, 32'd0, 1'b0, 2'd2, 1'b0, 32'd0, 1'b1);
        req(0, 32'h100, 32'd0, 1'b0, 2'd0, 1'b0, 32'd0, 1'b1);

        // Reset during ISSUE discards the transaction
        issue(0, 32'h10, 32'd0, 1'b0, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0);
        rst = 1'b1;
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("midrst_resp", {30'd0, resp_valid}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_resp", {30'd0, resp_valid}, 32'd0);
        end
        req(1, 32'h10, 32'd0, 1'b0, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
